// File: rtl/psg_pkg.sv
// Shared types and helpers for the pulse frame sequencer.
// Latency: n/a (types and elaboration-time functions only).
// Backpressure: n/a. PSG_ACK_SAMPLE_EN selects the guard-bit level (released '1' vs driven '0').
package psg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

`ifdef PSG_ACK_SAMPLE_EN
  // Guard bit releases the line so the receiver can pull it low as an ack.
  localparam logic GUARD_BIT = 1'b1;
`else
  localparam logic GUARD_BIT = 1'b0;
`endif

  // Start bit + 9 bits per byte (8 data + guard) + tail.
  function automatic int frame_len(input int num_bytes, input int tail_len);
    return 1 + 9 * num_bytes + tail_len;
  endfunction

  // Select-field width; at least one bit even for a single entry.
  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pulse_frame_sequencer_if.sv
// Board-side bundle of the sequencer: trigger, slot select, table writes, serial lines, status.
// Latency: n/a (wiring only).
// Backpressure: none; cfg writes are fire-and-forget strobes accepted every cycle.
interface pulse_frame_sequencer_if #(
  parameter int NUM_SLOTS = 2,
  parameter int NUM_BYTES = 4
);
  import psg_pkg::*;

  localparam int SW = width_of(NUM_SLOTS);
  localparam int IW = width_of(NUM_BYTES);

  logic          trigger_in;
  logic [SW-1:0] slot_sel_in;
  logic          cfg_we_in;
  logic [SW-1:0] cfg_slot_in;
  logic [IW-1:0] cfg_idx_in;
  logic [7:0]    cfg_data_in;
  logic          sda_in;
  logic          sclk_out;
  logic          sclk_stgr_out;
  logic          pulse_out;
  logic          busy_out;
  logic          done_out;
  logic          ack_err_out;

  modport master (
    output trigger_in, slot_sel_in, cfg_we_in, cfg_slot_in, cfg_idx_in, cfg_data_in, sda_in,
    input  sclk_out, sclk_stgr_out, pulse_out, busy_out, done_out, ack_err_out
  );

  modport slave (
    input  trigger_in, slot_sel_in, cfg_we_in, cfg_slot_in, cfg_idx_in, cfg_data_in, sda_in,
    output sclk_out, sclk_stgr_out, pulse_out, busy_out, done_out, ack_err_out
  );

endinterface

// File: rtl/psg_clk_tick.sv
// Serial-clock timebase: half-period counter, phase flag, bit-boundary and stagger-tap strobes.
// Latency: strobes are combinational from the counter; counting starts the cycle after run rises.
// Backpressure: none; run=0 holds the counter at its start point.
module psg_clk_tick #(
  parameter int CLK_DIV = 60
) (
  input  logic clk_in,
  input  logic reset_in,
  input  logic run,
  output logic phase,
  output logic half_end,
  output logic bit_end,
  output logic mid_tap
);

  localparam int HW = $clog2(CLK_DIV);
  localparam logic [HW-1:0] HC_LAST = HW'(CLK_DIV - 1);
  localparam logic [HW-1:0] HC_MID  = HW'(CLK_DIV / 2 - 1);

  logic [HW-1:0] hc;

  // Count half periods; phase 0 = serial clock low, 1 = high.
  always_ff @(posedge clk_in) begin
    if (reset_in || !run) begin
      hc    <= '0;
      phase <= 1'b0;
    end else if (hc == HC_LAST) begin
      hc    <= '0;
      phase <= ~phase;
    end else begin
      hc <= hc + 1'b1;
    end
  end

  assign half_end = run && (hc == HC_LAST);
  assign bit_end  = half_end && phase;
  // Halfway through a half period: stagger edge point, and ack sample point in the high phase.
  assign mid_tap  = run && (hc == HC_MID);

endmodule

// File: rtl/pulse_frame_sequencer.sv
// Button-triggered bit-serial frame generator with slot-selectable byte table (macro PSG_ACK_SAMPLE_EN).
// Latency: start bit on pulse_out 3 clk_in cycles after the trigger_in falling edge.
// Backpressure: triggers outside IDLE are dropped; table writes are accepted in every state.
module pulse_frame_sequencer
  import psg_pkg::*;
#(
  parameter int                  CLK_DIV      = 60,
  parameter int                  NUM_BYTES    = 4,
  parameter int                  NUM_SLOTS    = 2,
  parameter int                  TAIL_LEN     = 3,
  parameter logic [TAIL_LEN-1:0] TAIL_PATTERN = 3'b010
) (
  input logic                     clk_in,
  input logic                     reset_in,
  pulse_frame_sequencer_if.slave  bus
);

  localparam int FL = frame_len(NUM_BYTES, TAIL_LEN);
  localparam int BW = $clog2(FL);
  localparam int SW = width_of(NUM_SLOTS);
  localparam logic [BW-1:0] BIT_LAST = BW'(FL - 1);

  state_t        state;
  logic [BW-1:0] bit_cnt;
  logic [FL-1:0] shreg;
  logic [FL-1:0] frame_vec;
  logic [SW-1:0] sel_slot;
  logic [2:0]    trig_sync;
  logic          trig_fall;
  logic          pulse_q, sclk_q, stgr_q, busy_q, done_q;
  logic          run, phase, half_end, bit_end, mid_tap;
  logic [7:0]    byte_tbl [NUM_SLOTS][NUM_BYTES];

  // Two flops bring the button into clk_in; the third holds the previous level for edge detect.
  always_ff @(posedge clk_in) begin
    if (reset_in) trig_sync <= 3'b111;
    else          trig_sync <= {trig_sync[1:0], bus.trigger_in};
  end
  assign trig_fall = trig_sync[2] & ~trig_sync[1];

  // Byte table is deliberately not reset; out-of-range writes are dropped.
  always_ff @(posedge clk_in) begin
    if (bus.cfg_we_in && (int'(bus.cfg_slot_in) < NUM_SLOTS) && (int'(bus.cfg_idx_in) < NUM_BYTES))
      byte_tbl[bus.cfg_slot_in][bus.cfg_idx_in] <= bus.cfg_data_in;
  end

  // Assemble the whole frame from the selected slot, MSB = first bit on the wire.
  always_comb begin
    sel_slot  = (int'(bus.slot_sel_in) < NUM_SLOTS) ? bus.slot_sel_in : '0;
    frame_vec = '0;
    frame_vec[FL-1] = 1'b0;
    for (int b = 0; b < NUM_BYTES; b++) begin
      for (int i = 0; i < 8; i++)
        frame_vec[FL-2-9*b-i] = byte_tbl[sel_slot][b][7-i];
      frame_vec[FL-10-9*b] = GUARD_BIT;
    end
    frame_vec[TAIL_LEN-1:0] = TAIL_PATTERN;
  end

  assign run = (state != IDLE);

  psg_clk_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk_in   (clk_in),
    .reset_in (reset_in),
    .run      (run),
    .phase    (phase),
    .half_end (half_end),
    .bit_end  (bit_end),
    .mid_tap  (mid_tap)
  );

  // Frame FSM with all line outputs registered so they change exactly on bit/half-period edges.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state   <= IDLE;
      bit_cnt <= '0;
      shreg   <= '0;
      pulse_q <= 1'b1;
      sclk_q  <= 1'b1;
      stgr_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (trig_fall) begin
            state   <= SHIFT;
            bit_cnt <= '0;
            shreg   <= frame_vec;
            pulse_q <= frame_vec[FL-1];
            sclk_q  <= 1'b0;
            stgr_q  <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        SHIFT: begin
          if (bit_end) begin
            if (bit_cnt == BIT_LAST) begin
              state   <= GAP;
              pulse_q <= 1'b1;
              sclk_q  <= 1'b1;
              stgr_q  <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              shreg   <= {shreg[FL-2:0], 1'b0};
              pulse_q <= shreg[FL-2];
              sclk_q  <= 1'b0;
            end
          end else if (half_end) begin
            sclk_q <= 1'b1;
          end
          // Staggered clock follows the phase half a half-period late, except in the start bit.
          if (mid_tap && (bit_cnt != '0))
            stgr_q <= phase;
        end
        GAP: begin
          if (bit_end) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.pulse_out     = pulse_q;
  assign bus.sclk_out      = sclk_q;
  assign bus.sclk_stgr_out = stgr_q;
  assign bus.busy_out      = busy_q;
  assign bus.done_out      = done_q;

`ifdef PSG_ACK_SAMPLE_EN
  logic ack_seen, ack_err_q, is_guard;

  always_comb begin
    is_guard = (int'(bit_cnt) >= 9) && (int'(bit_cnt) <= 9 * NUM_BYTES) && ((int'(bit_cnt) % 9) == 0);
  end

  // Collect any missing ack over the frame; publish it with done, clear it on the next start.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      ack_seen  <= 1'b0;
      ack_err_q <= 1'b0;
    end else if ((state == IDLE) && trig_fall) begin
      ack_seen  <= 1'b0;
      ack_err_q <= 1'b0;
    end else if ((state == SHIFT) && mid_tap && phase && is_guard && bus.sda_in) begin
      ack_seen <= 1'b1;
    end else if ((state == GAP) && bit_end) begin
      ack_err_q <= ack_seen;
    end
  end

  assign bus.ack_err_out = ack_err_q;
`else
  logic unused_sda;
  assign unused_sda      = bus.sda_in;
  assign bus.ack_err_out = 1'b0;
`endif

endmodule

// File: tb/tb_pulse_frame_sequencer.sv
// Directed bench for pulse_frame_sequencer with CLK_DIV=4 and a bit-level scoreboard.
// Latency: expected frames are queued at trigger time and popped on each sclk rising edge.
// Backpressure: n/a; all waits on the DUT are cycle-bounded.
module tb_pulse_frame_sequencer;

  localparam int CLK_DIV = 4;
  localparam int NB      = 4;
  localparam int NS      = 2;
  localparam int TL      = 3;
  localparam int BITP    = 2 * CLK_DIV;
`ifdef PSG_ACK_SAMPLE_EN
  localparam logic EXP_GUARD = 1'b1;
  localparam logic ACK_EN    = 1'b1;
`else
  localparam logic EXP_GUARD = 1'b0;
  localparam logic ACK_EN    = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pulse_frame_sequencer_if #(.NUM_SLOTS(NS), .NUM_BYTES(NB)) bus ();

  pulse_frame_sequencer #(
    .CLK_DIV(CLK_DIV), .NUM_BYTES(NB), .NUM_SLOTS(NS), .TAIL_LEN(TL), .TAIL_PATTERN(3'b010)
  ) dut (
    .clk_in   (clk),
    .reset_in (rst),
    .bus      (bus)
  );

  int         errors = 0;
  int         checks = 0;
  int         cyc = 0;
  int         start_cyc = 0;
  int         done_cyc = 0;
  int         done_cnt = 0;
  int         stgr_edges = 0;
  int         sda_bit = -1;
  logic       exp_q[$];
  logic [7:0] tbl [NS][NB];
  logic [2:0] tail = 3'b010;
  logic       sclk_d1 = 1'b1, sclk_d2 = 1'b1, sclk_d3 = 1'b1, stgr_d1 = 1'b1;
  bit         chk_stgr = 1'b0;
  bit         stgr_start_bad = 1'b0;
  bit         busy_drop = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample outputs 1 time unit after the edge, score bits and stagger edges.
  task automatic tick();
    logic [31:0] e;
    @(posedge clk);
    #1;
    cyc++;
    if (sda_bit >= 0 && (cyc - start_cyc) >= sda_bit * BITP && (cyc - start_cyc) < (sda_bit + 1) * BITP)
      bus.sda_in = 1'b1;
    else
      bus.sda_in = 1'b0;
    if (bus.done_out) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (bus.busy_out && !sclk_d1 && bus.sclk_out) begin
      if (exp_q.size() > 0) e = {31'b0, exp_q.pop_front()};
      else                  e = 32'hDEAD;
      chk("frame_bit", {31'b0, bus.pulse_out}, e);
    end
    if (chk_stgr && (bus.sclk_stgr_out != stgr_d1)) begin
      stgr_edges++;
      chk("stgr_lag", {30'b0, sclk_d3, sclk_d2}, {30'b0, ~bus.sclk_stgr_out, bus.sclk_stgr_out});
    end
    if (chk_stgr && bus.busy_out && (cyc - start_cyc) < BITP && !bus.sclk_stgr_out)
      stgr_start_bad = 1'b1;
    sclk_d3 = sclk_d2;
    sclk_d2 = sclk_d1;
    sclk_d1 = bus.sclk_out;
    stgr_d1 = bus.sclk_stgr_out;
  endtask

  task automatic cfg_write(input int s, input int i, input logic [7:0] d);
    bus.cfg_we_in   = 1'b1;
    bus.cfg_slot_in = 1'(s);
    bus.cfg_idx_in  = 2'(i);
    bus.cfg_data_in = d;
    tick();
    bus.cfg_we_in = 1'b0;
    tbl[s][i] = d;
  endtask

  // Queue the expected frame from the bench table, then press the button and check latency.
  task automatic start_frame(input int slot);
    bus.slot_sel_in = 1'(slot);
    exp_q.push_back(1'b0);
    for (int b = 0; b < NB; b++) begin
      for (int i = 7; i >= 0; i--) exp_q.push_back(tbl[slot][b][i]);
      exp_q.push_back(EXP_GUARD);
    end
    for (int i = TL - 1; i >= 0; i--) exp_q.push_back(tail[i]);
    bus.trigger_in = 1'b0;
    tick();
    tick();
    chk("lat_pre_pulse", {31'b0, bus.pulse_out}, 32'd1);
    tick();
    start_cyc = cyc;
    chk("lat_start_pulse", {31'b0, bus.pulse_out}, 32'd0);
    chk("start_sclk", {31'b0, bus.sclk_out}, 32'd0);
    chk("start_busy", {31'b0, bus.busy_out}, 32'd1);
    chk("start_ack_clear", {31'b0, bus.ack_err_out}, 32'd0);
    bus.trigger_in = 1'b1;
  endtask

  task automatic wait_done(input int bound, input logic exp_ack);
    busy_drop = 1'b0;
    for (int i = 0; i < bound; i++) begin
      tick();
      if (bus.done_out) break;
      if (!bus.busy_out) busy_drop = 1'b1;
    end
    chk("done_seen", {31'b0, bus.done_out}, 32'd1);
    chk("busy_hold", {31'b0, busy_drop}, 32'd0);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    chk("ack_err", {31'b0, bus.ack_err_out}, {31'b0, exp_ack});
  endtask

  initial begin
    rst             = 1'b1;
    bus.trigger_in  = 1'b1;
    bus.slot_sel_in = '0;
    bus.cfg_we_in   = 1'b0;
    bus.cfg_slot_in = '0;
    bus.cfg_idx_in  = '0;
    bus.cfg_data_in = '0;
    bus.sda_in      = 1'b0;
    for (int s = 0; s < NS; s++)
      for (int b = 0; b < NB; b++) tbl[s][b] = 8'h00;

    // Reset state
    repeat (3) tick();
    chk("rst_pulse", {31'b0, bus.pulse_out}, 32'd1);
    chk("rst_sclk", {31'b0, bus.sclk_out}, 32'd1);
    chk("rst_stgr", {31'b0, bus.sclk_stgr_out}, 32'd1);
    chk("rst_busy", {31'b0, bus.busy_out}, 32'd0);
    chk("rst_done", {31'b0, bus.done_out}, 32'd0);
    chk("rst_ack", {31'b0, bus.ack_err_out}, 32'd0);
    rst = 1'b0;
    tick();

    cfg_write(0, 0, 8'h98); cfg_write(0, 1, 8'h98); cfg_write(0, 2, 8'h7E); cfg_write(0, 3, 8'h48);
    cfg_write(1, 0, 8'h98); cfg_write(1, 1, 8'h98); cfg_write(1, 2, 8'h00); cfg_write(1, 3, 8'h48);

    // Slot 0 frame, done latency and stagger relationship
    chk_stgr = 1'b1;
    stgr_edges = 0;
    stgr_start_bad = 1'b0;
    start_frame(0);
    wait_done(400, 1'b0);
    chk("done_latency", 32'(done_cyc - start_cyc), 32'd328);
    chk("stgr_edges", 32'(stgr_edges), 32'd78);
    chk("stgr_start_high", {31'b0, stgr_start_bad}, 32'd0);
    chk_stgr = 1'b0;
    repeat (5) tick();

    // Slot 1 frame with mid-frame select change and table rewrite
    start_frame(1);
    repeat (100) tick();
    bus.slot_sel_in = 1'b0;
    cfg_write(1, 2, 8'hFF);
    wait_done(400, 1'b0);
    repeat (5) tick();

    // Next slot 1 frame carries FF; a second button press mid-frame is ignored
    done_cnt = 0;
    start_frame(1);
    repeat (60) tick();
    bus.trigger_in = 1'b0;
    repeat (4) tick();
    bus.trigger_in = 1'b1;
    wait_done(400, 1'b0);
    repeat (60) tick();
    chk("single_done", 32'(done_cnt), 32'd1);
    chk("no_retrigger", {31'b0, bus.busy_out}, 32'd0);

    // Reset in the middle of bit 17
    done_cnt = 0;
    start_frame(0);
    repeat (17 * BITP + 4) tick();
    rst = 1'b1;
    tick();
    chk("abort_pulse", {31'b0, bus.pulse_out}, 32'd1);
    chk("abort_sclk", {31'b0, bus.sclk_out}, 32'd1);
    chk("abort_stgr", {31'b0, bus.sclk_stgr_out}, 32'd1);
    chk("abort_busy", {31'b0, bus.busy_out}, 32'd0);
    rst = 1'b0;
    exp_q.delete();
    repeat (400) tick();
    chk("abort_no_done", 32'(done_cnt), 32'd0);
    chk("abort_idle", {31'b0, bus.busy_out}, 32'd0);

    // Line held high during the third guard bit, then a clean frame
    sda_bit = 27;
    start_frame(0);
    wait_done(400, ACK_EN);
    repeat (5) tick();
    sda_bit = -1;
    start_frame(0);
    wait_done(400, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
